// File: rtl/rob_req_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rob_req_arb
//  Purpose  : Shares the single ROB request port among NREQ clients using a
//             round-robin grant. Each granted request is tagged with its source
//             index in the upper ROB ID bits and is registered toward the ROB.
//             In-order ROB responses are routed back to the client named by
//             those upper ID bits. Per-client outstanding counts stop a single
//             client from filling every ROB slot.
//  Ports    : clk, rst                      - clock, synchronous active-high reset
//             cli_req_val/addr/ID/param     - packed per-client request inputs
//             cli_req_ready                 - per-client accept (one-hot or zero)
//             rob_req_val/addr/ID/param     - registered request toward the ROB
//             rob_req_ready                 - ROB accept
//             rob_rsp_val/data/ID/param     - response from the ROB
//             rob_rsp_ready                 - always 1; clients must sink responses
//             cli_rsp_val                   - per-client response valid
//             cli_rsp_data/ID/param         - shared response payload
//             err                           - sticky protocol-error flag
//  Revision : 1.0 - initial release
// ============================================================================
module rob_req_arb #(
    parameter int NREQ      = 4,
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int PWIDTH    = 8,
    parameter int IDWIDTH   = 8,
    parameter int MAX_OUTST = 8,
    localparam int SRCW     = $clog2(NREQ),
    localparam int CIDW     = IDWIDTH - SRCW,
    localparam int CNTW     = $clog2(MAX_OUTST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          cli_req_val,
    input  logic [NREQ*AWIDTH-1:0]   cli_req_addr,
    input  logic [NREQ*CIDW-1:0]     cli_req_ID,
    input  logic [NREQ*PWIDTH-1:0]   cli_req_param,
    output logic [NREQ-1:0]          cli_req_ready,
    output logic                     rob_req_val,
    output logic [AWIDTH-1:0]        rob_req_addr,
    output logic [IDWIDTH-1:0]       rob_req_ID,
    output logic [PWIDTH-1:0]        rob_req_param,
    input  logic                     rob_req_ready,
    input  logic                     rob_rsp_val,
    input  logic [DWIDTH-1:0]        rob_rsp_data,
    input  logic [IDWIDTH-1:0]       rob_rsp_ID,
    input  logic [PWIDTH-1:0]        rob_rsp_param,
    output logic                     rob_rsp_ready,
    output logic [NREQ-1:0]          cli_rsp_val,
    output logic [DWIDTH-1:0]        cli_rsp_data,
    output logic [CIDW-1:0]          cli_rsp_ID,
    output logic [PWIDTH-1:0]        cli_rsp_param,
    output logic                     err
);

    localparam logic [CNTW-1:0] c_max_cnt  = CNTW'(MAX_OUTST);
    localparam logic [SRCW-1:0] c_last_idx = SRCW'(NREQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SRCW-1:0]    r_ptr;
    logic [CNTW-1:0]    r_cnt [NREQ];
    logic               r_val;
    logic [AWIDTH-1:0]  r_addr;
    logic [IDWIDTH-1:0] r_id;
    logic [PWIDTH-1:0]  r_param;
    logic               r_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic               w_load_en;
    logic [NREQ-1:0]    w_elig;
    logic               w_any;
    logic [SRCW-1:0]    w_gidx;
    logic [SRCW-1:0]    w_ptr_nxt;
    logic [NREQ-1:0]    w_grant;
    logic [NREQ-1:0]    w_inc;
    logic [NREQ-1:0]    w_dec;
    logic [AWIDTH-1:0]  w_nxt_addr;
    logic [IDWIDTH-1:0] w_nxt_id;
    logic [PWIDTH-1:0]  w_nxt_param;
    logic [SRCW-1:0]    w_src;
    logic               w_src_nz;
    logic               w_rsp_ok;
    logic               w_rsp_bad;

    // The output register can take a new request when it is empty or its
    // current content is leaving this cycle.
    assign w_load_en = !r_val || rob_req_ready;

    // Eligibility looks only at the registered count, so a response this
    // cycle cannot unblock a saturated client until the next cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = cli_req_val[i] && (r_cnt[i] < c_max_cnt);
        end
    end

    // Round-robin search starting at r_ptr, wrapping modulo NREQ.
    always_comb begin
        int              idx;
        logic [SRCW-1:0] sel;
        w_any  = 1'b0;
        w_gidx = '0;
        idx    = 0;
        sel    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(r_ptr) + k) % NREQ;
            sel = idx[SRCW-1:0];
            if (!w_any && w_elig[sel]) begin
                w_any  = 1'b1;
                w_gidx = sel;
            end
        end
    end

    // Decode the winner and select its payload, tagging the ID with the
    // source index so the response can be routed back.
    always_comb begin
        w_grant     = '0;
        w_nxt_addr  = '0;
        w_nxt_id    = '0;
        w_nxt_param = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == SRCW'(i)) begin
                w_grant[i]  = w_any;
                w_nxt_addr  = cli_req_addr[i*AWIDTH +: AWIDTH];
                w_nxt_id    = {SRCW'(i), cli_req_ID[i*CIDW +: CIDW]};
                w_nxt_param = cli_req_param[i*PWIDTH +: PWIDTH];
            end
        end
    end

    assign w_ptr_nxt     = (w_gidx == c_last_idx) ? '0 : w_gidx + 1'b1;
    assign w_inc         = w_load_en ? w_grant : '0;
    assign cli_req_ready = (w_load_en && !rst) ? w_grant : '0;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign w_src = rob_rsp_ID[IDWIDTH-1 -: SRCW];

    // Non-zero count of the addressed client; stays 0 for a source index
    // beyond NREQ-1, which folds the out-of-range case into the same check.
    always_comb begin
        w_src_nz = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_src == SRCW'(i)) begin
                w_src_nz = (r_cnt[i] != '0);
            end
        end
    end

    assign w_rsp_ok  = rob_rsp_val && w_src_nz;
    assign w_rsp_bad = rob_rsp_val && !w_src_nz;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_dec[i]       = w_rsp_ok && (w_src == SRCW'(i));
            cli_rsp_val[i] = w_dec[i] && !rst;
        end
    end

    assign cli_rsp_data  = rst ? '0 : rob_rsp_data;
    assign cli_rsp_ID    = rst ? '0 : rob_rsp_ID[CIDW-1:0];
    assign cli_rsp_param = rst ? '0 : rob_rsp_param;
    assign rob_rsp_ready = 1'b1;

    // ------------------------------------------------------------------
    // Output register and pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val   <= 1'b0;
            r_addr  <= '0;
            r_id    <= '0;
            r_param <= '0;
            r_ptr   <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_val   <= 1'b1;
                r_addr  <= w_nxt_addr;
                r_id    <= w_nxt_id;
                r_param <= w_nxt_param;
                r_ptr   <= w_ptr_nxt;
            end else begin
                r_val   <= 1'b0;
            end
        end
    end

    // Outstanding counters; a grant and a response for the same client in
    // one cycle cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !w_dec[i]) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end else if (w_dec[i] && !w_inc[i]) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_rsp_bad) begin
            r_err <= 1'b1;
        end
    end

    assign rob_req_val   = r_val;
    assign rob_req_addr  = r_addr;
    assign rob_req_ID    = r_id;
    assign rob_req_param = r_param;
    assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rob_req_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_req_arb
//  Purpose  : Self-checking bench for rob_req_arb. The bench acts as the ROB
//             (an in-order queue of accepted requests) and keeps a reference
//             model in which a client's outstanding count is derived from the
//             ROB queue contents plus the output-register entry.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rob_req_arb;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int PW   = 8;
    localparam int IDW  = 8;
    localparam int MAXO = 8;
    localparam int SRCW = 2;
    localparam int CIDW = IDW - SRCW;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [IDW-1:0] id;
        logic [PW-1:0]  param;
    } req_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      cli_req_val;
    logic [NREQ*AW-1:0]   cli_req_addr;
    logic [NREQ*CIDW-1:0] cli_req_ID;
    logic [NREQ*PW-1:0]   cli_req_param;
    logic [NREQ-1:0]      cli_req_ready;
    logic                 rob_req_val;
    logic [AW-1:0]        rob_req_addr;
    logic [IDW-1:0]       rob_req_ID;
    logic [PW-1:0]        rob_req_param;
    logic                 rob_req_ready;
    logic                 rob_rsp_val;
    logic [DW-1:0]        rob_rsp_data;
    logic [IDW-1:0]       rob_rsp_ID;
    logic [PW-1:0]        rob_rsp_param;
    logic                 rob_rsp_ready;
    logic [NREQ-1:0]      cli_rsp_val;
    logic [DW-1:0]        cli_rsp_data;
    logic [CIDW-1:0]      cli_rsp_ID;
    logic [PW-1:0]        cli_rsp_param;
    logic                 err;

    rob_req_arb #(
        .NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .PWIDTH(PW),
        .IDWIDTH(IDW), .MAX_OUTST(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .cli_req_val(cli_req_val), .cli_req_addr(cli_req_addr),
        .cli_req_ID(cli_req_ID), .cli_req_param(cli_req_param),
        .cli_req_ready(cli_req_ready),
        .rob_req_val(rob_req_val), .rob_req_addr(rob_req_addr),
        .rob_req_ID(rob_req_ID), .rob_req_param(rob_req_param),
        .rob_req_ready(rob_req_ready),
        .rob_rsp_val(rob_rsp_val), .rob_rsp_data(rob_rsp_data),
        .rob_rsp_ID(rob_rsp_ID), .rob_rsp_param(rob_rsp_param),
        .rob_rsp_ready(rob_rsp_ready),
        .cli_rsp_val(cli_rsp_val), .cli_rsp_data(cli_rsp_data),
        .cli_rsp_ID(cli_rsp_ID), .cli_rsp_param(cli_rsp_param),
        .err(err)
    );

    always #5 clk = ~clk;

    // Reference model state
    req_t rob_q[$];
    bit   m_or_val;
    req_t m_or;
    int   m_ptr;
    bit   m_err;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Outstanding requests of client c: everything the ROB holds for it
    // plus the entry waiting in the output register.
    function automatic int outst(input int c);
        int n = 0;
        foreach (rob_q[j]) if (int'(rob_q[j].id[IDW-1 -: SRCW]) == c) n++;
        if (m_or_val && int'(m_or.id[IDW-1 -: SRCW]) == c) n++;
        return n;
    endfunction

    task automatic model_reset();
        rob_q.delete();
        m_or_val = 1'b0;
        m_or     = '{addr: '0, id: '0, param: '0};
        m_ptr    = 0;
        m_err    = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, advance model at the
    // rising edge, then hand control back 1 time unit later for new inputs.
    task automatic step();
        bit              ld, found, ok;
        int              g, c, src;
        logic [NREQ-1:0] exp_rdy, exp_rv;
        @(negedge clk);
        ld    = !m_or_val || rob_req_ready;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (!found && cli_req_val[c] && outst(c) < MAXO) begin
                found = 1'b1;
                g     = c;
            end
        end
        exp_rdy = (rst || !ld || !found) ? '0 : NREQ'(1 << g);
        src     = int'(rob_rsp_ID[IDW-1 -: SRCW]);
        ok      = rob_rsp_val && (outst(src) > 0);
        exp_rv  = (ok && !rst) ? NREQ'(1 << src) : '0;

        chk("cli_req_ready", 64'(cli_req_ready), 64'(exp_rdy));
        chk("cli_rsp_val",   64'(cli_rsp_val),   64'(exp_rv));
        if (ok && !rst) begin
            chk("cli_rsp_ID",    64'(cli_rsp_ID),    64'(rob_rsp_ID[CIDW-1:0]));
            chk("cli_rsp_data",  64'(cli_rsp_data),  64'(rob_rsp_data));
            chk("cli_rsp_param", 64'(cli_rsp_param), 64'(rob_rsp_param));
        end
        if (rst) begin
            chk("cli_rsp_data_rst", 64'(cli_rsp_data), 64'd0);
            chk("cli_rsp_ID_rst",   64'(cli_rsp_ID),   64'd0);
        end
        chk("rob_req_val", 64'(rob_req_val), 64'(m_or_val));
        if (m_or_val) begin
            chk("rob_req_addr",  64'(rob_req_addr),  64'(m_or.addr));
            chk("rob_req_ID",    64'(rob_req_ID),    64'(m_or.id));
            chk("rob_req_param", 64'(rob_req_param), 64'(m_or.param));
        end
        chk("err", 64'(err), 64'(m_err));
        chk("rob_rsp_ready", 64'(rob_rsp_ready), 64'd1);

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (rob_rsp_val && !ok) m_err = 1'b1;
            if (ok) void'(rob_q.pop_front());
            if (m_or_val && rob_req_ready) rob_q.push_back(m_or);
            if (ld) begin
                if (found) begin
                    m_or.addr  = cli_req_addr[g*AW +: AW];
                    m_or.id    = {g[SRCW-1:0], cli_req_ID[g*CIDW +: CIDW]};
                    m_or.param = cli_req_param[g*PW +: PW];
                    m_or_val   = 1'b1;
                    m_ptr      = (g + 1) % NREQ;
                end else begin
                    m_or_val   = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic rand_payload();
        for (int c = 0; c < NREQ; c++) begin
            cli_req_addr[c*AW +: AW]    = $urandom;
            cli_req_ID[c*CIDW +: CIDW]  = CIDW'($urandom);
            cli_req_param[c*PW +: PW]   = PW'($urandom);
        end
        rob_rsp_data  = $urandom;
        rob_rsp_param = PW'($urandom);
    endtask

    // Drive a response for the head of the ROB queue when asked and possible.
    task automatic rsp_head(input bit want);
        rob_rsp_val = want && (rob_q.size() > 0);
        rob_rsp_ID  = (rob_q.size() > 0) ? rob_q[0].id : IDW'($urandom);
    endtask

    initial begin
        rst           = 1'b1;
        cli_req_val   = '0;
        cli_req_addr  = '0;
        cli_req_ID    = '0;
        cli_req_param = '0;
        rob_req_ready = 1'b0;
        rob_rsp_val   = 1'b0;
        rob_rsp_data  = '0;
        rob_rsp_ID    = '0;
        rob_rsp_param = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state, with a client requesting while reset is held
        cli_req_val = 4'b1111;
        step();
        chk("rst_addr",  64'(rob_req_addr),  64'd0);
        chk("rst_ID",    64'(rob_req_ID),    64'd0);
        chk("rst_param", 64'(rob_req_param), 64'd0);
        rst = 1'b0;

        // All clients valid, ROB always ready, no responses: 0,1,2,3,...
        // until every client reaches MAX_OUTST, then stall.
        rob_req_ready = 1'b1;
        for (int i = 0; i < NREQ * MAXO + 4; i++) begin
            rand_payload();
            rsp_head(1'b0);
            step();
        end

        // Drain with requests held: saturated clients are re-granted as
        // their responses come back.
        for (int i = 0; i < 60; i++) begin
            rand_payload();
            rsp_head(1'b1);
            step();
        end

        // Client 2 only, ROB stalls 3 cycles while a request is pending
        cli_req_val = 4'b0100;
        for (int i = 0; i < 60; i++) begin
            rsp_head(1'b1);
            step();
        end
        rand_payload();
        rsp_head(1'b0);
        step();
        rob_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            step();
        end
        rob_req_ready = 1'b1;
        step();

        // Randomized traffic with varying response pressure
        for (int seg = 0; seg < 8; seg++) begin
            for (int i = 0; i < 300; i++) begin
                rand_payload();
                cli_req_val   = NREQ'($urandom);
                rob_req_ready = ($urandom_range(0, 3) != 0);
                rsp_head($urandom_range(0, 3) < (seg % 4));
                step();
            end
        end

        // Drain everything, then return a response nobody is waiting for
        cli_req_val   = '0;
        rob_req_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            rsp_head(1'b1);
            step();
        end
        rob_rsp_val = 1'b1;
        rob_rsp_ID  = 8'h45;
        step();
        rob_rsp_val = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Reset mid-operation with the output register loaded
        cli_req_val   = 4'b1111;
        rob_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            step();
        end
        rob_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_payload();
            step();
        end
        rsp_head(1'b0);
        rob_rsp_ID = rob_q[0].id;
        rst        = 1'b1;
        step();
        rst         = 1'b0;
        cli_req_val = '0;
        step();
        // A stale in-flight response after reset is an error
        rob_rsp_val = 1'b1;
        step();
        rob_rsp_val = 1'b0;
        for (int i = 0; i < 3; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
